// File: rtl/craft_round_controller_pkg.sv
// Shared constants and state encoding for the CRAFT round sequencer and its datapath.
// Slot 0 of every round is the CK0 slot; nibbles occupy slots 1..NIBBLES.
package craft_round_controller_pkg;

    localparam int CRAFT_NUM_ROUNDS = 32;
    localparam int CRAFT_NIBBLES    = 16;
    localparam int CRAFT_ROUND_W    = 8;
    localparam int CRAFT_NIB_W      = 4;
    localparam int CRAFT_CK0_SLOT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int slot_width(input int nibbles);
        return $clog2(nibbles + 1);
    endfunction

endpackage

// File: rtl/craft_slot_counter.sv
// Modulo-(MAX+1) slot counter with synchronous clear; exposes its next value so the
// owner can register outputs decoded from the upcoming slot.
module craft_slot_counter #(
    parameter int MAX = 16,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] next_count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_r;

    // Next-count selection: clear dominates, wrap returns to slot 0.
    always_comb begin
        wrap       = (count_r == MAX_V);
        next_count = count_r;
        if (clr) begin
            next_count = {W{1'b0}};
        end else if (inc) begin
            if (wrap) begin
                next_count = {W{1'b0}};
            end else begin
                next_count = count_r + W'(1);
            end
        end else begin
            next_count = count_r;
        end
    end

    // Slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= next_count;
        end
    end

endmodule

// File: rtl/craft_round_controller.sv
// Round sequencer for the nibble-serial CRAFT core: IDLE -> LOAD -> ROUND -> DONE.
// Every output is a flop fed by the decoded next state, so start/abort never reach outputs combinationally.
module craft_round_controller
    import craft_round_controller_pkg::*;
#(
    parameter int NUM_ROUNDS = CRAFT_NUM_ROUNDS,
    parameter int NIBBLES    = CRAFT_NIBBLES,
    parameter int ROUND_W    = CRAFT_ROUND_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   load_kt,
    output logic                   ck0,
    output logic                   en,
    output logic [ROUND_W-1:0]     r,
    output logic [CRAFT_NIB_W-1:0] nib_idx,
    output logic                   nib_valid,
    output logic                   last_round,
    output logic                   busy,
    output logic                   done
);

    localparam int                 SLOT_W = slot_width(NIBBLES);
    localparam logic [ROUND_W-1:0] LAST_K = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [SLOT_W-1:0]  CK0_S  = SLOT_W'(CRAFT_CK0_SLOT);

    state_t                   state_r;
    state_t                   state_s;
    logic [ROUND_W-1:0]       round_r;
    logic [ROUND_W-1:0]       round_s;
    logic [SLOT_W-1:0]        slot_s;
    logic                     slot_wrap_s;
    logic                     slot_clr_s;
    logic                     slot_inc_s;
    logic                     in_round_s;
    logic                     slot0_s;
    logic [CRAFT_NIB_W-1:0]   nib_idx_s;

    craft_slot_counter #(
        .MAX (NIBBLES),
        .W   (SLOT_W)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (slot_clr_s),
        .inc        (slot_inc_s),
        .next_count (slot_s),
        .wrap       (slot_wrap_s)
    );

    // Next-state decode; abort outranks everything except reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (slot_wrap_s && (round_r == LAST_K)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Slot and round counter control; the round index is held through DONE.
    always_comb begin
        slot_clr_s = 1'b1;
        slot_inc_s = 1'b0;
        round_s    = {ROUND_W{1'b0}};
        if ((state_r == ST_ROUND) && (state_s == ST_ROUND)) begin
            slot_clr_s = 1'b0;
            slot_inc_s = 1'b1;
        end else begin
            slot_clr_s = 1'b1;
            slot_inc_s = 1'b0;
        end
        if (state_s == ST_ROUND) begin
            if (state_r != ST_ROUND) begin
                round_s = {ROUND_W{1'b0}};
            end else if (slot_wrap_s) begin
                round_s = round_r + ROUND_W'(1);
            end else begin
                round_s = round_r;
            end
        end else if (state_s == ST_DONE) begin
            round_s = round_r;
        end else begin
            round_s = {ROUND_W{1'b0}};
        end
    end

    // Output decode of the upcoming cycle.
    always_comb begin
        in_round_s = (state_s == ST_ROUND);
        slot0_s    = (slot_s == CK0_S);
        nib_idx_s  = {CRAFT_NIB_W{1'b0}};
        if (in_round_s && !slot0_s) begin
            nib_idx_s = CRAFT_NIB_W'(slot_s - SLOT_W'(1));
        end else begin
            nib_idx_s = {CRAFT_NIB_W{1'b0}};
        end
    end

    // State, round counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            round_r    <= {ROUND_W{1'b0}};
            load_kt    <= 1'b0;
            ck0        <= 1'b0;
            en         <= 1'b0;
            r          <= {ROUND_W{1'b0}};
            nib_idx    <= {CRAFT_NIB_W{1'b0}};
            nib_valid  <= 1'b0;
            last_round <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            round_r    <= round_s;
            load_kt    <= (state_s == ST_LOAD);
            ck0        <= in_round_s && slot0_s;
            en         <= in_round_s && (round_s != LAST_K);
            r          <= round_s;
            nib_idx    <= nib_idx_s;
            nib_valid  <= in_round_s && !slot0_s;
            last_round <= in_round_s && (round_s == LAST_K);
            busy       <= (state_s == ST_LOAD) || in_round_s;
            done       <= (state_s == ST_DONE);
        end
    end

endmodule
